// File: rtl/bypass_scoreboard_pkg.sv
// rtl/bypass_scoreboard_pkg.sv - shared pipeline types for the operand bypass scoreboard
// Contents: XLEN_DEF / NUM_REGS_DEF defaults, regaddr_t register address type,
//           rd_data_sel producer-source enum.
package bypass_scoreboard_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 16;
  localparam int REG_AW       = $clog2(NUM_REGS_DEF);

  typedef logic [REG_AW-1:0] regaddr_t;

  // Which unit produces a stage's destination value.
  typedef enum logic [1:0] {
    SEL_ALU = 2'd0,
    SEL_PC4 = 2'd1,
    SEL_LSU = 2'd2
  } rd_data_sel;

endpackage

// File: rtl/bypass_scoreboard_if.sv
// rtl/bypass_scoreboard_if.sv - issue/stage/retire/operand bundle between ID and the scoreboard
// Signals: flush, issue_valid/we/rd, stg_we/rd/data/data_valid per stage,
//          retire_valid/rd, rs_addr/rf_data per port (to scoreboard),
//          rs_data/rs_ready per port and stall (from scoreboard).
// Modports: master = pipeline side, slave = scoreboard side.
interface bypass_scoreboard_if #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 16,
  parameter int NUM_STAGES   = 4,
  parameter int NUM_RD_PORTS = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic                    flush;
  logic                    issue_valid;
  logic                    issue_we;
  logic [AW-1:0]           issue_rd;
  logic [NUM_STAGES-1:0]   stg_we;
  logic [AW-1:0]           stg_rd [NUM_STAGES];
  logic [XLEN-1:0]         stg_data [NUM_STAGES];
  logic [NUM_STAGES-1:0]   stg_data_valid;
  logic                    retire_valid;
  logic [AW-1:0]           retire_rd;
  logic [AW-1:0]           rs_addr [NUM_RD_PORTS];
  logic [XLEN-1:0]         rf_data [NUM_RD_PORTS];
  logic [XLEN-1:0]         rs_data [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] rs_ready;
  logic                    stall;

  modport master (
    output flush, issue_valid, issue_we, issue_rd,
    output stg_we, stg_rd, stg_data, stg_data_valid,
    output retire_valid, retire_rd, rs_addr, rf_data,
    input  rs_data, rs_ready, stall
  );

  modport slave (
    input  flush, issue_valid, issue_we, issue_rd,
    input  stg_we, stg_rd, stg_data, stg_data_valid,
    input  retire_valid, retire_rd, rs_addr, rf_data,
    output rs_data, rs_ready, stall
  );

endinterface

// File: rtl/bypass_scoreboard_port_mux.sv
// rtl/bypass_scoreboard_port_mux.sv - per-read-port youngest-stage operand select (module bypass_port_mux)
// Ports: rs_addr, rf_data, stg_we/rd/data/data_valid, pend_zero (in);
//        rs_data, rs_ready (out); fwd_hit (out, only with BYPASS_PERF_EN).
module bypass_port_mux #(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 16,
  parameter int NUM_STAGES = 4
) (
  input  logic [$clog2(NUM_REGS)-1:0] rs_addr,
  input  logic [XLEN-1:0]             rf_data,
  input  logic [NUM_STAGES-1:0]       stg_we,
  input  logic [$clog2(NUM_REGS)-1:0] stg_rd [NUM_STAGES],
  input  logic [XLEN-1:0]             stg_data [NUM_STAGES],
  input  logic [NUM_STAGES-1:0]       stg_data_valid,
  input  logic                        pend_zero,
  output logic [XLEN-1:0]             rs_data,
  output logic                        rs_ready
`ifdef BYPASS_PERF_EN
  ,
  output logic                        fwd_hit
`endif
);

  // Scan oldest to youngest so the youngest match is the last one written.
  // A younger match that is not yet valid masks every older one.
  always_comb begin
    rs_data  = rf_data;
    rs_ready = pend_zero;
`ifdef BYPASS_PERF_EN
    fwd_hit  = 1'b0;
`endif
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (stg_we[i] && (stg_rd[i] == rs_addr)) begin
        rs_ready = stg_data_valid[i];
        rs_data  = stg_data_valid[i] ? stg_data[i] : rf_data;
`ifdef BYPASS_PERF_EN
        fwd_hit  = stg_data_valid[i];
`endif
      end
    end
    if (rs_addr == '0) begin
      rs_data  = '0;
      rs_ready = 1'b1;
`ifdef BYPASS_PERF_EN
      fwd_hit  = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/bypass_scoreboard.sv
// rtl/bypass_scoreboard.sv - pending-write scoreboard with stage bypass and ID stall
// Ports: clk, rst_n (async active-low); bus (bypass_scoreboard_if.slave);
//        perf_stall_cycles, perf_fwd_hits (32-bit, only with BYPASS_PERF_EN).
module bypass_scoreboard
  import bypass_scoreboard_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int NUM_REGS     = NUM_REGS_DEF,
  parameter int NUM_STAGES   = 4,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bypass_scoreboard_if.slave   bus
`ifdef BYPASS_PERF_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_fwd_hits
`endif
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_STAGES + 2);
  localparam logic [CW-1:0] PEND_MAX = CW'(NUM_STAGES + 1);

  logic [CW-1:0]           pending [NUM_REGS];
  logic [NUM_RD_PORTS-1:0] pend_zero;
  logic [NUM_RD_PORTS-1:0] port_ready;
  logic [XLEN-1:0]         port_data [NUM_RD_PORTS];
  logic [NUM_REGS-1:0]     inc_hit;
  logic [NUM_REGS-1:0]     dec_hit;
  logic                    stall_int;
  logic                    do_inc;
  logic                    do_dec;
`ifdef BYPASS_PERF_EN
  logic [NUM_RD_PORTS-1:0] fwd_hit;
  logic [31:0]             hit_cnt;
`endif

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    assign pend_zero[p] = (pending[bus.rs_addr[p]] == '0);

    bypass_port_mux #(
      .XLEN       (XLEN),
      .NUM_REGS   (NUM_REGS),
      .NUM_STAGES (NUM_STAGES)
    ) u_mux (
      .rs_addr        (bus.rs_addr[p]),
      .rf_data        (bus.rf_data[p]),
      .stg_we         (bus.stg_we),
      .stg_rd         (bus.stg_rd),
      .stg_data       (bus.stg_data),
      .stg_data_valid (bus.stg_data_valid),
      .pend_zero      (pend_zero[p]),
      .rs_data        (port_data[p]),
      .rs_ready       (port_ready[p])
`ifdef BYPASS_PERF_EN
      ,
      .fwd_hit        (fwd_hit[p])
`endif
    );

    assign bus.rs_data[p] = port_data[p];
  end

  assign bus.rs_ready = port_ready;

  // Stall checks every port regardless of which sources the instruction uses;
  // it is forced low during reset and flush.
  assign stall_int = rst_n & ~bus.flush & bus.issue_valid & ~(&port_ready);
  assign bus.stall = stall_int;

  assign do_inc = bus.issue_valid & bus.issue_we & (bus.issue_rd != '0) & ~stall_int;
  assign do_dec = bus.retire_valid & (bus.retire_rd != '0);

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_hit[r] = do_inc & (bus.issue_rd == AW'(r));
      dec_hit[r] = do_dec & (bus.retire_rd == AW'(r));
    end
  end

  // Issue and retire to the same register cancel; both directions saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) pending[r] <= '0;
    end else if (bus.flush) begin
      for (int r = 0; r < NUM_REGS; r++) pending[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_hit[r] && !dec_hit[r] && (pending[r] != PEND_MAX)) begin
          pending[r] <= pending[r] + CW'(1);
        end else if (dec_hit[r] && !inc_hit[r] && (pending[r] != '0)) begin
          pending[r] <= pending[r] - CW'(1);
        end
      end
    end
  end

`ifdef BYPASS_PERF_EN
  always_comb begin
    hit_cnt = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) hit_cnt = hit_cnt + 32'(fwd_hit[p]);
  end

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_fwd_hits     <= '0;
    end else begin
      if (stall_int) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (bus.issue_valid && !stall_int && !bus.flush) perf_fwd_hits <= perf_fwd_hits + hit_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_bypass_scoreboard.sv
// tb/tb_bypass_scoreboard.sv - self-checking bench for bypass_scoreboard (optional BYPASS_PERF_EN)
module tb_bypass_scoreboard;
  import bypass_scoreboard_pkg::*;

  localparam int NS = 4;
  localparam int NP = 2;
  localparam int NR = 16;
  localparam int PMAX = NS + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bypass_scoreboard_if #(.XLEN(32), .NUM_REGS(NR), .NUM_STAGES(NS), .NUM_RD_PORTS(NP)) bus ();

`ifdef BYPASS_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_fwd_hits;
`endif

  bypass_scoreboard #(.XLEN(32), .NUM_REGS(NR), .NUM_STAGES(NS), .NUM_RD_PORTS(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BYPASS_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_fwd_hits     (perf_fwd_hits)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pend [NR];
  int unsigned m_stall = 0;
  int unsigned m_hits = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.flush = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_we = 1'b0;
    bus.issue_rd = '0;
    bus.stg_we = '0;
    bus.stg_data_valid = '0;
    for (int i = 0; i < NS; i++) begin
      bus.stg_rd[i] = '0;
      bus.stg_data[i] = '0;
    end
    bus.retire_valid = 1'b0;
    bus.retire_rd = '0;
    for (int p = 0; p < NP; p++) begin
      bus.rs_addr[p] = '0;
      bus.rf_data[p] = $urandom;
    end
  endtask

  task automatic set_stage(input int i, input int rd, input logic [31:0] d, input logic v);
    bus.stg_we[i] = 1'b1;
    bus.stg_rd[i] = 4'(rd);
    bus.stg_data[i] = d;
    bus.stg_data_valid[i] = v;
  endtask

  task automatic issue(input int rd);
    bus.issue_valid = 1'b1;
    bus.issue_we = 1'b1;
    bus.issue_rd = 4'(rd);
  endtask

  // Reference operand: x0 is constant zero, else the first (youngest) matching
  // stage decides, else the register file subject to outstanding writes.
  task automatic model_port(input int p, output logic [31:0] d, output logic r, output logic h);
    regaddr_t a;
    a = bus.rs_addr[p];
    d = bus.rf_data[p];
    r = (pend[a] == 0);
    h = 1'b0;
    if (a == 0) begin
      d = 0;
      r = 1'b1;
      return;
    end
    for (int i = 0; i < NS; i++) begin
      if (bus.stg_we[i] && bus.stg_rd[i] == a) begin
        r = bus.stg_data_valid[i];
        d = r ? bus.stg_data[i] : bus.rf_data[p];
        h = r;
        return;
      end
    end
  endtask

  // Compare all outputs against the model, then advance the model to the next edge.
  task automatic cmp_cycle(input string tag);
    logic [31:0] d;
    logic r, h, any_nr, exp_stall, inc, dec;
    int hits;
    regaddr_t ird, rrd;
    #1;
    if (!rst_n) begin
      foreach (pend[k]) pend[k] = 0;
      m_stall = 0;
      m_hits = 0;
    end
    any_nr = 1'b0;
    hits = 0;
    for (int p = 0; p < NP; p++) begin
      model_port(p, d, r, h);
      check($sformatf("%s_data%0d", tag, p), bus.rs_data[p], d);
      check($sformatf("%s_ready%0d", tag, p), 32'(bus.rs_ready[p]), 32'(r));
      if (!r) any_nr = 1'b1;
      if (h) hits++;
    end
    exp_stall = rst_n && !bus.flush && bus.issue_valid && any_nr;
    check($sformatf("%s_stall", tag), 32'(bus.stall), 32'(exp_stall));
    if (rst_n) begin
      if (exp_stall) m_stall++;
      if (bus.issue_valid && !exp_stall && !bus.flush) m_hits += hits;
      if (bus.flush) begin
        foreach (pend[k]) pend[k] = 0;
      end else begin
        ird = bus.issue_rd;
        rrd = bus.retire_rd;
        inc = bus.issue_valid && bus.issue_we && ird != 0 && !exp_stall;
        dec = bus.retire_valid && rrd != 0;
        if (!(inc && dec && ird == rrd)) begin
          if (inc && pend[ird] < PMAX) pend[ird]++;
          if (dec && pend[rrd] > 0) pend[rrd]--;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    foreach (pend[k]) pend[k] = 0;
    idle();
    bus.issue_valid = 1'b1;
    cmp_cycle("reset");
    tick();
    rst_n = 1'b1;

    // Forward an ALU result for x5.
    idle(); issue(5); cmp_cycle("iss5"); tick();
    idle(); set_stage(0, 5, 32'h1234, 1'b1); bus.rs_addr[0] = 4'd5; bus.issue_valid = 1'b1;
    cmp_cycle("fwd5");
    check("fwd5_lit", bus.rs_data[0], 32'h1234);
    check("fwd5_nostall", 32'(bus.stall), 32'd0);
    tick();

    // Load-use on x3.
    idle(); issue(3); cmp_cycle("iss3"); tick();
    idle(); set_stage(0, 3, 32'h0, 1'b0); bus.rs_addr[0] = 4'd3; bus.issue_valid = 1'b1;
    cmp_cycle("ld3a");
    check("ld3_stall", 32'(bus.stall), 32'd1);
    tick();
    idle(); set_stage(0, 3, 32'hCAFE, 1'b1); bus.rs_addr[0] = 4'd3; bus.issue_valid = 1'b1;
    cmp_cycle("ld3b");
    check("ld3_data", bus.rs_data[0], 32'hCAFE);
    check("ld3_go", 32'(bus.stall), 32'd0);
    tick();

    // Youngest match wins; an invalid younger match blocks older data.
    idle(); set_stage(0, 7, 32'hA, 1'b1); set_stage(2, 7, 32'hB, 1'b1);
    bus.rs_addr[0] = 4'd7; bus.issue_valid = 1'b1;
    cmp_cycle("prio_a");
    check("prio_a_lit", bus.rs_data[0], 32'hA);
    tick();
    idle(); set_stage(0, 7, 32'hA, 1'b0); set_stage(2, 7, 32'hB, 1'b1);
    bus.rs_addr[0] = 4'd7; bus.rf_data[0] = 32'h55; bus.issue_valid = 1'b1;
    cmp_cycle("prio_b");
    check("prio_b_stall", 32'(bus.stall), 32'd1);
    check("prio_b_notB", bus.rs_data[0], 32'h55);
    tick();

    // Same-cycle issue and retire on x9.
    idle(); issue(9); cmp_cycle("iss9"); tick();
    idle(); issue(9); bus.retire_valid = 1'b1; bus.retire_rd = 4'd9; cmp_cycle("both9"); tick();
    idle(); bus.rs_addr[0] = 4'd9; bus.retire_valid = 1'b1; bus.retire_rd = 4'd9;
    cmp_cycle("hold9");
    check("hold9_busy", 32'(bus.rs_ready[0]), 32'd0);
    tick();
    idle(); bus.rs_addr[0] = 4'd9; cmp_cycle("free9");
    check("free9_ready", 32'(bus.rs_ready[0]), 32'd1);
    check("free9_rf", bus.rs_data[0], bus.rf_data[0]);
    tick();

    // Flush clears everything and beats a simultaneous issue.
    for (int k = 0; k < 3; k++) begin
      idle(); issue(4); cmp_cycle("iss4"); tick();
    end
    idle(); bus.flush = 1'b1; issue(4); bus.rs_addr[0] = 4'd4;
    cmp_cycle("flush");
    check("flush_nostall", 32'(bus.stall), 32'd0);
    tick();
    idle(); bus.rs_addr[0] = 4'd4; cmp_cycle("post_flush");
    check("post_flush_ready", 32'(bus.rs_ready[0]), 32'd1);
    check("post_flush_rf", bus.rs_data[0], bus.rf_data[0]);
    tick();

    // Counter saturates at NS+1: seven issues then exactly five retires free x2.
    for (int k = 0; k < 7; k++) begin
      idle(); issue(2); cmp_cycle("sat_iss"); tick();
    end
    for (int k = 0; k < PMAX; k++) begin
      idle(); bus.retire_valid = 1'b1; bus.retire_rd = 4'd2; bus.rs_addr[0] = 4'd2;
      cmp_cycle("sat_ret");
      check("sat_busy", 32'(bus.rs_ready[0]), 32'd0);
      tick();
    end
    idle(); bus.rs_addr[0] = 4'd2; cmp_cycle("sat_done");
    check("sat_free", 32'(bus.rs_ready[0]), 32'd1);
    tick();

    // x0 never forwards.
    idle(); set_stage(0, 0, 32'hFFFF, 1'b1); bus.rs_addr[1] = 4'd0; bus.issue_valid = 1'b1;
    cmp_cycle("x0");
    check("x0_data", bus.rs_data[1], 32'd0);
    check("x0_ready", 32'(bus.rs_ready[1]), 32'd1);
    tick();

    // Asynchronous reset mid-run, observed before any clock edge.
    idle(); issue(6); cmp_cycle("iss6"); tick();
    idle(); rst_n = 1'b0; bus.rs_addr[0] = 4'd6; bus.rs_addr[1] = 4'd12;
    set_stage(1, 12, 32'h0, 1'b0); bus.issue_valid = 1'b1;
    cmp_cycle("rst_async");
    check("rst_x6_ready", 32'(bus.rs_ready[0]), 32'd1);
    check("rst_nostall", 32'(bus.stall), 32'd0);
    tick();
    rst_n = 1'b1;

`ifdef BYPASS_PERF_EN
    for (int k = 0; k < 10; k++) begin
      idle(); set_stage(0, 1, 32'h0, 1'b0); bus.rs_addr[0] = 4'd1; bus.issue_valid = 1'b1;
      cmp_cycle("perf_stall"); tick();
    end
    check("perf_stall10", perf_stall_cycles, 32'd10);
`endif

    for (int c = 0; c < 600; c++) begin
      idle();
      bus.flush = ($urandom_range(0, 31) == 0);
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_we = ($urandom_range(0, 3) != 0);
      bus.issue_rd = 4'($urandom_range(0, 5));
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 2) == 0) set_stage(i, $urandom_range(0, 5), $urandom, ($urandom_range(0, 3) != 0));
      end
      bus.retire_valid = 1'($urandom_range(0, 1));
      bus.retire_rd = 4'($urandom_range(0, 5));
      for (int p = 0; p < NP; p++) bus.rs_addr[p] = 4'($urandom_range(0, 5));
      cmp_cycle("rnd");
      tick();
    end

`ifdef BYPASS_PERF_EN
    check("perf_stall_total", perf_stall_cycles, 32'(m_stall));
    check("perf_hits_total", perf_fwd_hits, 32'(m_hits));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
